// File: rtl/piso_serializer_if.sv
// Parallel-load / serial-out handshake bundle between an upstream word source,
// the serializer and the downstream serial consumer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_first;
    logic             frame_last;

    modport master (
        output parallel_in, load_valid, shift_en,
        input  load_ready, serial_out, serial_valid, frame_first, frame_last
    );

    modport slave (
        input  parallel_in, load_valid, shift_en,
        output load_ready, serial_out, serial_valid, frame_first, frame_last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready word loading, downstream
// stall control and back-to-back reload on the last bit.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              reset,
    piso_serializer_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             frame_first_q, frame_first_d;
    logic             frame_last_q, frame_last_d;

    logic             at_last_c;
    logic             load_ready_c;
    logic             accept_c;
    logic [WIDTH-1:0] shifted_c;

    // Handshake: a new word may enter when idle or as the last bit leaves.
    always_comb begin
        at_last_c    = (state_q == SHIFT) && (bit_cnt_q == LAST_CNT);
        load_ready_c = !reset && ((state_q == IDLE) || (at_last_c && bus.shift_en));
        accept_c     = bus.load_valid && load_ready_c;
        shifted_c    = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, shreg_q[WIDTH-1:1]};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
        frame_first_d  = 1'b0;
        frame_last_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d   = SHIFT;
                    shreg_d   = bus.parallel_in;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (at_last_c) begin
                        if (accept_c) begin
                            shreg_d   = bus.parallel_in;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = IDLE;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        shreg_d   = shifted_c;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs describe the bit that will sit on the line after this edge.
        if (state_d == SHIFT) begin
            serial_out_d   = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
            serial_valid_d = 1'b1;
            frame_first_d  = (bit_cnt_d == '0);
            frame_last_d   = (bit_cnt_d == LAST_CNT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_first_q  <= 1'b0;
            frame_last_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            frame_first_q  <= frame_first_d;
            frame_last_q   <= frame_last_d;
        end
    end

    assign bus.load_ready   = load_ready_c;
    assign bus.serial_out   = serial_out_q;
    assign bus.serial_valid = serial_valid_q;
    assign bus.frame_first  = frame_first_q;
    assign bus.frame_last   = frame_last_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer, expected bit
// streams queued on each accept and checked by per-DUT monitors on negedge.
module tb_piso_serializer;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_bit_t;

    logic clk;
    logic reset;

    piso_serializer_if #(.WIDTH(W)) ifm ();
    piso_serializer_if #(.WIDTH(W)) ifl ();

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (ifm.slave)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (ifl.slave)
    );

    exp_bit_t q_msb[$];
    exp_bit_t q_lsb[$];
    int       n_chk  = 0;
    int       n_fail = 0;
    logic [W-1:0] sipo;
    int       sipo_shifts;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line order: first bit carries frame_first, eighth frame_last.
    task automatic push_word(input bit lsb, input logic [W-1:0] w);
        exp_bit_t e;
        for (int k = 0; k < W; k++) begin
            e.b     = lsb ? w[k] : w[W-1-k];
            e.first = (k == 0);
            e.last  = (k == W - 1);
            if (lsb) q_lsb.push_back(e);
            else     q_msb.push_back(e);
        end
    endtask

    task automatic send(input bit lsb, input logic [W-1:0] w);
        bit done = 1'b0;
        int n = 0;
        if (lsb) begin ifl.parallel_in = w; ifl.load_valid = 1'b1; end
        else     begin ifm.parallel_in = w; ifm.load_valid = 1'b1; end
        while (!done) begin
            if (lsb ? ifl.load_ready : ifm.load_ready) begin
                push_word(lsb, w);
                done = 1'b1;
            end
            step();
            n++;
            if (!done && n > 50) begin
                chk("send_timeout", 32'd1, 32'd0);
                done = 1'b1;
            end
        end
        if (lsb) ifl.load_valid = 1'b0;
        else     ifm.load_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit lsb);
        int n = 0;
        while ((lsb ? q_lsb.size() : q_msb.size()) != 0 && n < 100) begin
            step();
            n++;
        end
        chk(lsb ? "lsb_drain" : "msb_drain", lsb ? q_lsb.size() : q_msb.size(), 32'd0);
    endtask

    // Monitors: compare the presented bit every valid cycle, retire it when shift_en lets it go.
    always @(negedge clk) begin
        if (ifm.serial_valid) begin
            if (q_msb.size() == 0) begin
                chk("msb_unexpected_valid", 32'(ifm.serial_valid), 32'd0);
            end else begin
                chk("msb_bit",   32'(ifm.serial_out),  32'(q_msb[0].b));
                chk("msb_first", 32'(ifm.frame_first), 32'(q_msb[0].first));
                chk("msb_last",  32'(ifm.frame_last),  32'(q_msb[0].last));
                if (ifm.shift_en) void'(q_msb.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (ifl.serial_valid) begin
            if (q_lsb.size() == 0) begin
                chk("lsb_unexpected_valid", 32'(ifl.serial_valid), 32'd0);
            end else begin
                chk("lsb_bit",   32'(ifl.serial_out),  32'(q_lsb[0].b));
                chk("lsb_first", 32'(ifl.frame_first), 32'(q_lsb[0].first));
                chk("lsb_last",  32'(ifl.frame_last),  32'(q_lsb[0].last));
                if (ifl.shift_en) void'(q_lsb.pop_front());
            end
        end
    end

    // Downstream 8-bit SIPO fed LSB-first from the LSB serializer.
    always @(posedge clk) begin
        if (reset) begin
            sipo        <= '0;
            sipo_shifts <= 0;
        end else if (ifl.serial_valid && ifl.shift_en) begin
            sipo        <= {ifl.serial_out, sipo[W-1:1]};
            sipo_shifts <= sipo_shifts + 1;
        end
    end

    initial begin
        reset = 1'b1;
        ifm.parallel_in = '0; ifm.load_valid = 1'b0; ifm.shift_en = 1'b1;
        ifl.parallel_in = '0; ifl.load_valid = 1'b0; ifl.shift_en = 1'b1;

        // Reset values before any clock edge.
        #2;
        chk("rst_serial_out",   32'(ifm.serial_out),   32'd0);
        chk("rst_serial_valid", 32'(ifm.serial_valid), 32'd0);
        chk("rst_frame_first",  32'(ifm.frame_first),  32'd0);
        chk("rst_frame_last",   32'(ifm.frame_last),   32'd0);
        chk("rst_load_ready",   32'(ifm.load_ready),   32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_load_ready", 32'(ifm.load_ready), 32'd1);

        // Single word A5, then idle on cycle 9.
        send(1'b0, 8'hA5);
        repeat (8) step();
        chk("single_valid_c9", 32'(ifm.serial_valid), 32'd0);
        chk("single_out_c9",   32'(ifm.serial_out),   32'd0);
        chk("single_ready_c9", 32'(ifm.load_ready),   32'd1);
        wait_drain(1'b0);

        // Back-to-back A5 then 3C: reload on the cycle-8 edge, no gap.
        send(1'b0, 8'hA5);
        ifm.parallel_in = 8'h3C;
        ifm.load_valid  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            chk("b2b_valid", 32'(ifm.serial_valid), 32'd1);
            if (ifm.load_valid && ifm.load_ready) begin
                chk("b2b_accept_cycle", 32'(c), 32'd8);
                push_word(1'b0, 8'h3C);
                step();
                ifm.load_valid = 1'b0;
            end else begin
                step();
            end
        end
        chk("b2b_idle_after", 32'(ifm.serial_valid), 32'd0);
        wait_drain(1'b0);

        // Stall on bit 3 of F0 for 3 cycles.
        send(1'b0, 8'hF0);
        step();
        step();
        ifm.shift_en = 1'b0;
        chk("stall_bit3", 32'(ifm.serial_out), 32'd1);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_hold_out",   32'(ifm.serial_out),   32'd1);
            chk("stall_hold_valid", 32'(ifm.serial_valid), 32'd1);
            chk("stall_hold_first", 32'(ifm.frame_first),  32'd0);
            chk("stall_hold_last",  32'(ifm.frame_last),   32'd0);
        end
        ifm.shift_en = 1'b1;
        wait_drain(1'b0);
        step();

        // Busy reject: FF offered while bit_cnt == 2.
        send(1'b0, 8'hA5);
        step();
        step();
        ifm.parallel_in = 8'hFF;
        ifm.load_valid  = 1'b1;
        chk("busy_load_ready", 32'(ifm.load_ready), 32'd0);
        step();
        chk("busy_load_ready2", 32'(ifm.load_ready), 32'd0);
        ifm.load_valid = 1'b0;
        wait_drain(1'b0);
        step();
        chk("busy_idle_after", 32'(ifm.serial_valid), 32'd0);

        // Reset mid-word at bit 4 of A5, asserted between edges.
        send(1'b0, 8'hA5);
        repeat (3) step();
        #2;
        reset = 1'b1;
        q_msb.delete();
        #1;
        chk("midrst_serial_out",   32'(ifm.serial_out),   32'd0);
        chk("midrst_serial_valid", 32'(ifm.serial_valid), 32'd0);
        chk("midrst_frame_first",  32'(ifm.frame_first),  32'd0);
        chk("midrst_frame_last",   32'(ifm.frame_last),   32'd0);
        chk("midrst_load_ready",   32'(ifm.load_ready),   32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("midrst_release_ready", 32'(ifm.load_ready),   32'd1);
        chk("midrst_release_valid", 32'(ifm.serial_valid), 32'd0);
        step();
        chk("midrst_stays_idle", 32'(ifm.serial_valid), 32'd0);

        // LSB-first 01 into the SIPO.
        send(1'b1, 8'h01);
        wait_drain(1'b1);
        step();
        chk("sipo_shifts", 32'(sipo_shifts), 32'd8);
        chk("sipo_word",   32'(sipo),        32'h01);
        chk("lsb_idle",    32'(ifl.serial_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, 8, parallel word width in bits (>= 2).
REQ-002 SHALL have parameter: MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: parallel_in  input  WIDTH  word to serialize; sampled only on an accepting edge.
REQ-006 SHALL have port: load_valid  input  1  upstream offers parallel_in.
REQ-007 SHALL have port: load_ready  output  1  block can accept a word this cycle (combinational).
REQ-008 SHALL have port: shift_en  input  1  downstream permits advancing to the next bit; 0 stalls.
REQ-009 SHALL have port: serial_out  output  1  current serial bit (registered); feeds the downstream SIPO serial_in.
REQ-010 SHALL have port: serial_valid  output  1  serial_out holds a valid data bit (registered).
REQ-011 SHALL have port: frame_first  output  1  high while serial_out is bit 1 of a word.
REQ-012 SHALL have port: frame_last  output  1  high while serial_out is bit WIDTH of a word.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no word in flight) and SHIFT (word in flight).
REQ-014 SHALL hold a WIDTH-bit shift register and a bit counter of $clog2(WIDTH) bits, counting 0..WIDTH-1.
REQ-015 SHALL define accept = load_valid && load_ready at a rising edge.
REQ-016 SHALL drive load_ready = !reset && (state==IDLE || (state==SHIFT && bit_cnt==WIDTH-1 && shift_en)).
REQ-017 On accept, SHALL load parallel_in, set bit_cnt=0, and enter SHIFT. On the cycle after the accepting edge, serial_out SHALL equal the first bit and serial_valid=1, frame_first=1.
REQ-018 In SHIFT with shift_en=1 and bit_cnt<WIDTH-1, SHALL shift by one position toward the output end and increment bit_cnt.
REQ-019 In SHIFT with shift_en=0, SHALL hold the shift register, bit_cnt, serial_out, frame_first and frame_last unchanged.
REQ-020 frame_first SHALL equal (state==SHIFT && bit_cnt==0). frame_last SHALL equal (state==SHIFT && bit_cnt==WIDTH-1).
REQ-021 At bit_cnt==WIDTH-1 with shift_en=1: with accept, SHALL load the new word and stay in SHIFT with no idle gap. Without accept, SHALL return to IDLE with serial_valid=0.
REQ-022 In IDLE, serial_out SHALL be 0 and serial_valid, frame_first and frame_last SHALL be 0.
REQ-023 load_valid while load_ready=0 SHALL be ignored. parallel_in SHALL NOT be re-sampled mid-word.
REQ-024 Latency: from the accepting edge, bit k (1..WIDTH) SHALL appear k cycles later when shift_en stays high.
REQ-025 With MSB_FIRST=0, the bit order SHALL be LSB first. All other timing SHALL be identical.

Reset
REQ-026 While reset=1, the block SHALL set state=IDLE, the shift register to 0 and bit_cnt to 0. serial_out, serial_valid, frame_first, frame_last and load_ready SHALL all be 0, immediately and without waiting for clk.
REQ-027 Reset asserted mid-word SHALL discard the word in flight. After reset deasserts, the block SHALL be in IDLE with load_ready=1.

Verification
REQ-028 Single word: WIDTH=8, MSB_FIRST=1, shift_en=1, accept 8'hA5 -> serial_out 1,0,1,0,0,1,0,1 on cycles 1..8, frame_first on cycle 1 only, frame_last on cycle 8 only, serial_valid=0 on cycle 9.
REQ-029 Back-to-back: accept 8'hA5, then keep load_valid=1 with 8'h3C -> second accept on the cycle-8 edge, 16 contiguous valid bits ending 0,0,1,1,1,1,0,0, no serial_valid gap.
REQ-030 Stall: 8'hF0, shift_en=0 for 3 cycles while bit 3 is on the line -> serial_out=1 held for 4 cycles total, bit_cnt frozen, remaining bits unchanged.
REQ-031 Busy reject: in SHIFT at bit_cnt=2, load_valid=1 with 8'hFF -> load_ready=0, word ignored, current word completes unaltered.
REQ-032 Reset mid-word: assert reset between clock edges at bit 4 of 8'hA5 -> all outputs 0 before the next edge. After release: IDLE, load_ready=1.
REQ-033 LSB-first: MSB_FIRST=0, accept 8'h01 -> serial_out 1,0,0,0,0,0,0,0. Chained into an 8-bit SIPO, the captured word SHALL match after 8 shifts.
